// File: rtl/keypad_scan_debounce.sv
// ROWSxCOLS matrix keypad scanner with frame debounce, valid/ack handshake and 7-seg readout.
// Optional auto-repeat of a held key is enabled by defining REPEAT_EN.
module keypad_scan_debounce #(
  parameter int ROWS     = 4,
  parameter int COLS     = 4,
  parameter int SCAN_DIV = 49_999,
  parameter int DEBOUNCE = 4,
  parameter int REP_DLY  = 25,
  parameter int REP_RATE = 5,
  localparam int CODE_W  = (ROWS * COLS > 1) ? $clog2(ROWS * COLS) : 1
) (
  input  logic              Clk,
  input  logic              Rst,
  input  logic [ROWS-1:0]   read,
  output logic [COLS-1:0]   scan,
  output logic [CODE_W-1:0] key_code,
  output logic              key_valid,
  input  logic              key_ack,
  output logic              key_held,
  output logic              overrun,
  output logic [6:0]        display
);
  localparam int DIV_W = (SCAN_DIV > 0) ? $clog2(SCAN_DIV + 1) : 1;
  localparam int COL_W = (COLS > 1) ? $clog2(COLS) : 1;
  localparam int CNT_W = $clog2(DEBOUNCE + 1) + 1;

  typedef enum logic [1:0] {S_IDLE, S_DEBNC, S_PRESSED, S_RELEASE} state_t;

  function automatic logic [6:0] seg7(input logic [3:0] v);
    case (v)
      4'h0: seg7 = 7'b0000001;
      4'h1: seg7 = 7'b1001111;
      4'h2: seg7 = 7'b0010010;
      4'h3: seg7 = 7'b0000110;
      4'h4: seg7 = 7'b1001100;
      4'h5: seg7 = 7'b0100100;
      4'h6: seg7 = 7'b0100000;
      4'h7: seg7 = 7'b0001111;
      4'h8: seg7 = 7'b0000000;
      4'h9: seg7 = 7'b0000100;
      4'hA: seg7 = 7'b0001000;
      4'hB: seg7 = 7'b1100000;
      4'hC: seg7 = 7'b0110001;
      4'hD: seg7 = 7'b1000010;
      4'hE: seg7 = 7'b0110000;
      4'hF: seg7 = 7'b0111000;
    endcase
  endfunction

  logic [DIV_W-1:0]  div;
  logic [COL_W-1:0]  col;
  logic              tick, frame_end;
  logic [1:0]        col_hits, acc_hits, f_hits;
  logic [2:0]        tot_hits;
  logic [CODE_W-1:0] col_code, acc_code, f_code;
  logic              f_none, f_single;
  state_t            state, state_n;
  logic [CNT_W-1:0]  cnt, cnt_n, cnt_inc;
  logic [CODE_W-1:0] cand, cand_n;
  logic              accept;

  assign tick      = (div == DIV_W'(SCAN_DIV));
  assign frame_end = tick && (col == COL_W'(COLS - 1));

  // Column dwell divider and scan pointer
  always_ff @(posedge Clk) begin
    if (Rst) begin
      div <= '0;
      col <= '0;
    end else if (tick) begin
      div <= '0;
      col <= (col == COL_W'(COLS - 1)) ? '0 : col + COL_W'(1);
    end else begin
      div <= div + DIV_W'(1);
    end
  end

  always_comb begin
    scan      = '1;
    scan[col] = 1'b0;
  end

  // Per-column sample: hit count saturates at 2, which is all a frame needs to know
  always_comb begin
    col_hits = 2'd0;
    col_code = '0;
    for (int r = 0; r < ROWS; r++) begin
      if (!read[ROWS-1-r]) begin
        if (col_hits != 2'd2) col_hits = col_hits + 2'd1;
        col_code = CODE_W'(r * COLS) + CODE_W'(col);
      end
    end
  end

  assign tot_hits = {1'b0, acc_hits} + {1'b0, col_hits};
  assign f_hits   = (tot_hits >= 3'd2) ? 2'd2 : tot_hits[1:0];
  assign f_code   = (acc_hits != 2'd0) ? acc_code : col_code;
  assign f_none   = (f_hits == 2'd0);
  assign f_single = (f_hits == 2'd1);

  // Frame accumulator, restarted after the last column of every frame
  always_ff @(posedge Clk) begin
    if (Rst) begin
      acc_hits <= 2'd0;
      acc_code <= '0;
    end else if (tick) begin
      if (col == COL_W'(COLS - 1)) begin
        acc_hits <= 2'd0;
        acc_code <= '0;
      end else begin
        acc_hits <= f_hits;
        acc_code <= f_code;
      end
    end
  end

  assign cnt_inc = cnt + CNT_W'(1);

`ifdef REPEAT_EN
  localparam int REP_MAX = (REP_DLY > REP_RATE) ? REP_DLY : REP_RATE;
  localparam int REP_W   = $clog2(REP_MAX + 1) + 1;
  logic [REP_W-1:0] rep_cnt, rep_cnt_n, rep_inc, rep_target;
  logic             rep_first, rep_first_n;
  assign rep_inc    = rep_cnt + REP_W'(1);
  assign rep_target = rep_first ? REP_W'(REP_DLY) : REP_W'(REP_RATE);
`endif

  always_ff @(posedge Clk) begin
    if (Rst) begin
      state <= S_IDLE;
      cnt   <= '0;
      cand  <= '0;
`ifdef REPEAT_EN
      rep_cnt   <= '0;
      rep_first <= 1'b1;
`endif
    end else begin
      state <= state_n;
      cnt   <= cnt_n;
      cand  <= cand_n;
`ifdef REPEAT_EN
      rep_cnt   <= rep_cnt_n;
      rep_first <= rep_first_n;
`endif
    end
  end

  always_comb begin
    state_n = state;
    cnt_n   = cnt;
    cand_n  = cand;
    accept  = 1'b0;
`ifdef REPEAT_EN
    rep_cnt_n   = rep_cnt;
    rep_first_n = rep_first;
`endif
    if (frame_end) begin
      case (state)
        S_IDLE: begin
          if (f_single) begin
            cand_n = f_code;
            if (DEBOUNCE <= 1) begin
              accept  = 1'b1;
              state_n = S_PRESSED;
            end else begin
              state_n = S_DEBNC;
              cnt_n   = CNT_W'(1);
            end
          end
        end
        S_DEBNC: begin
          if (f_single && f_code == cand) begin
            if (cnt_inc >= CNT_W'(DEBOUNCE)) begin
              accept  = 1'b1;
              state_n = S_PRESSED;
            end else begin
              cnt_n = cnt_inc;
            end
          end else begin
            state_n = S_IDLE;
          end
        end
        S_PRESSED: begin
          if (f_none || (f_single && f_code != cand)) begin
            state_n = S_RELEASE;
            cnt_n   = CNT_W'(1);
          end else begin
`ifdef REPEAT_EN
            if (rep_inc == rep_target) begin
              accept      = 1'b1;
              rep_cnt_n   = '0;
              rep_first_n = 1'b0;
            end else begin
              rep_cnt_n = rep_inc;
            end
`endif
          end
        end
        S_RELEASE: begin
          if (f_none) begin
            if (cnt_inc >= CNT_W'(DEBOUNCE)) state_n = S_IDLE;
            else cnt_n = cnt_inc;
          end else if (f_single && f_code == cand) begin
            state_n = S_PRESSED;
          end else begin
            cnt_n = CNT_W'(1);
          end
        end
        default: state_n = S_IDLE;
      endcase
`ifdef REPEAT_EN
      if (state_n != S_PRESSED) begin
        rep_cnt_n   = '0;
        rep_first_n = 1'b1;
      end
`endif
    end
  end

  assign key_held = (state == S_PRESSED) || (state == S_RELEASE);

  // Handshake: an accept wins over a plain ack; an ack landing with an accept frees the slot
  always_ff @(posedge Clk) begin
    if (Rst) begin
      key_code  <= '0;
      key_valid <= 1'b0;
      overrun   <= 1'b0;
      display   <= 7'h7F;
    end else if (accept) begin
      if (!key_valid || key_ack) begin
        key_code  <= cand_n;
        key_valid <= 1'b1;
        display   <= seg7(4'(cand_n));
      end else begin
        overrun <= 1'b1;
      end
    end else if (key_ack) begin
      key_valid <= 1'b0;
    end
  end
endmodule

// File: tb/tb_keypad_scan_debounce.sv
// Bench for keypad_scan_debounce: emulated key matrix, frame-level reference model, scoreboard.
module tb_keypad_scan_debounce;
  localparam int ROWS = 4, COLS = 4, SCAN_DIV = 3, DEB = 2, REP_DLY = 3, REP_RATE = 2;
  localparam int FRAME = COLS * (SCAN_DIV + 1);

  logic       clk = 1'b0;
  logic       Rst;
  logic [3:0] read, scan, key_code;
  logic       key_valid, key_ack, key_held, overrun;
  logic [6:0] display;
  logic [15:0] keys;
  logic       man_ack, ack_q, auto_ack;
  int         n_checks = 0, n_errors = 0, acc_seen = 0;
  int         exp_q[$];

  logic [6:0] seg_tab [16] = '{7'b0000001, 7'b1001111, 7'b0010010, 7'b0000110,
                               7'b1001100, 7'b0100100, 7'b0100000, 7'b0001111,
                               7'b0000000, 7'b0000100, 7'b0001000, 7'b1100000,
                               7'b0110001, 7'b1000010, 7'b0110000, 7'b0111000};

  keypad_scan_debounce #(.ROWS(ROWS), .COLS(COLS), .SCAN_DIV(SCAN_DIV), .DEBOUNCE(DEB),
                         .REP_DLY(REP_DLY), .REP_RATE(REP_RATE)) dut (
    .Clk(clk), .Rst(Rst), .read(read), .scan(scan), .key_code(key_code),
    .key_valid(key_valid), .key_ack(key_ack), .key_held(key_held),
    .overrun(overrun), .display(display));

  always #5 clk = ~clk;
  assign key_ack = auto_ack ? ack_q : man_ack;

  // Physical matrix: a pressed key pulls its row low while its column is driven
  always_comb begin
    read = '1;
    for (int c = 0; c < COLS; c++)
      if (!scan[c])
        for (int r = 0; r < ROWS; r++)
          if (keys[r*COLS+c]) read[ROWS-1-r] = 1'b0;
  end

  task automatic check(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_errors++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  // Reference model, one call per scan frame
  int m_cand, m_agree, m_quiet, m_age;
  bit m_held, m_first;

  task automatic model_reset();
    m_cand = -1; m_agree = 0; m_quiet = 0; m_age = 0; m_held = 0; m_first = 1;
    exp_q.delete();
  endtask

  task automatic model_frame(input logic [15:0] p);
    int n, k;
    bit acc;
    n = $countones(p);
    k = -1;
    acc = 0;
    for (int i = 0; i < 16; i++) if (p[i]) k = i;
    if (!m_held) begin
      if (n == 1 && (m_agree == 0 || k == m_cand)) begin
        if (m_agree == 0) m_cand = k;
        m_agree++;
        if (m_agree >= DEB) begin
          m_held = 1; m_quiet = 0; m_age = 0; m_first = 1; acc = 1;
        end
      end else begin
        m_agree = 0;
      end
    end else if (m_quiet == 0) begin
      if (n == 0 || (n == 1 && k != m_cand)) begin
        m_quiet = 1; m_age = 0; m_first = 1;
      end else begin
`ifdef REPEAT_EN
        m_age++;
        if (m_age == (m_first ? REP_DLY : REP_RATE)) begin
          acc = 1; m_age = 0; m_first = 0;
        end
`endif
      end
    end else begin
      if (n == 0) begin
        m_quiet++;
        if (m_quiet >= DEB) begin m_held = 0; m_agree = 0; end
      end else if (n == 1 && k == m_cand) begin
        m_quiet = 0; m_age = 0; m_first = 1;
      end else begin
        m_quiet = 1;
      end
    end
    if (acc && auto_ack) exp_q.push_back(m_cand);
  endtask

  // Starts and ends on a falling edge aligned to a frame boundary
  task automatic run_frame(input logic [15:0] p, input bit ack_end);
    keys = p;
    model_frame(p);
    repeat (FRAME - 1) @(posedge clk);
    @(negedge clk);
    if (ack_end) man_ack = 1'b1;
    @(posedge clk);
    @(negedge clk);
    man_ack = 1'b0;
  endtask

  task automatic do_reset();
    @(negedge clk);
    Rst = 1'b1; keys = '0; man_ack = 1'b0;
    repeat (3) @(posedge clk);
    model_reset();
    @(negedge clk);
    Rst = 1'b0;
  endtask

  task automatic pulse_ack();
    man_ack = 1'b1;
    @(posedge clk);
    @(negedge clk);
    man_ack = 1'b0;
  endtask

  task automatic monitor();
    logic pv;
    int e;
    pv = 1'b0;
    forever begin
      @(negedge clk);
      ack_q = 1'b0;
      if (auto_ack && !Rst && key_valid && !pv) begin
        acc_seen++;
        if (exp_q.size() == 0) begin
          n_checks++; n_errors++;
          $display("FAIL sb_unexpected: got key %0d, expected no key", key_code);
        end else begin
          e = exp_q.pop_front();
          check("sb_code", int'(key_code), e);
          check("sb_display", int'(display), int'(seg_tab[e]));
          check("sb_overrun", int'(overrun), 0);
        end
        ack_q = 1'b1;
      end
      pv = key_valid;
    end
  endtask

  initial begin
    logic [3:0]  es;
    logic [15:0] pat;
    int a, b, r;
    Rst = 1'b1; keys = '0; man_ack = 1'b0; ack_q = 1'b0; auto_ack = 1'b0;
    model_reset();
    fork
      monitor();
    join_none

    do_reset();
    check("rst_scan", int'(scan), 4'b1110);
    check("rst_display", int'(display), 7'h7F);
    check("rst_valid", int'(key_valid), 0);
    check("rst_held", int'(key_held), 0);
    check("rst_overrun", int'(overrun), 0);
    check("rst_code", int'(key_code), 0);
    for (int i = 0; i < COLS; i++) begin
      es = 4'b1111;
      es[i] = 1'b0;
      check("scan_walk", int'(scan), int'(es));
      repeat (SCAN_DIV + 1) @(posedge clk);
      @(negedge clk);
    end

    run_frame(16'h1 << 6, 0);
    check("k6_latency_f1", int'(key_valid), 0);
    run_frame(16'h1 << 6, 0);
    run_frame(16'h1 << 6, 0);
    check("k6_valid", int'(key_valid), 1);
    check("k6_code", int'(key_code), 6);
    check("k6_display", int'(display), 7'b0100000);
    check("k6_held", int'(key_held), 1);
    run_frame('0, 0);
    run_frame('0, 0);
    check("k6_released", int'(key_held), 0);

    do_reset();
    run_frame(16'h1, 0);
    repeat (3) run_frame('0, 0);
    check("short_press_valid", int'(key_valid), 0);
    check("short_press_held", int'(key_held), 0);
    repeat (3) run_frame((16'h1 << 1) | (16'h1 << 4), 0);
    check("multi_valid", int'(key_valid), 0);
    check("multi_held", int'(key_held), 0);
    repeat (3) run_frame((16'h1 << 1) | (16'h1 << 9), 0);
    check("multi_samecol_valid", int'(key_valid), 0);

    do_reset();
    run_frame(16'h1 << 2, 0);
    do_reset();
    run_frame(16'h1 << 2, 0);
    check("midrst_valid", int'(key_valid), 0);
    run_frame(16'h1 << 2, 0);
    check("midrst_restart_valid", int'(key_valid), 1);
    check("midrst_restart_code", int'(key_code), 2);

    do_reset();
    repeat (2) run_frame(16'h1 << 5, 0);
    check("k5_valid", int'(key_valid), 1);
    repeat (2) run_frame('0, 0);
    repeat (2) run_frame(16'h1 << 9, 0);
    check("ovr_flag", int'(overrun), 1);
    check("ovr_code_kept", int'(key_code), 5);
    check("ovr_display_kept", int'(display), int'(seg_tab[5]));
    pulse_ack();
    check("ovr_ack_clears", int'(key_valid), 0);
    check("ovr_sticky", int'(overrun), 1);

    do_reset();
    repeat (2) run_frame(16'h1 << 7, 0);
    check("k7_code", int'(key_code), 7);
    repeat (2) run_frame('0, 0);
    run_frame(16'h1 << 3, 0);
    run_frame(16'h1 << 3, 1);
    check("ackacc_valid", int'(key_valid), 1);
    check("ackacc_code", int'(key_code), 3);
    check("ackacc_overrun", int'(overrun), 0);
    check("ackacc_display", int'(display), 7'b0000110);
    pulse_ack();
    check("ack_after", int'(key_valid), 0);

    do_reset();
    auto_ack = 1'b1;
    acc_seen = 0;
    pat = '0;
    for (int f = 0; f < 90; f++) begin
      r = $urandom_range(0, 99);
      if (r < 55) begin
        pat = pat;
      end else if (r < 72) begin
        pat = '0;
      end else if (r < 92) begin
        pat = 16'h1 << $urandom_range(0, 15);
      end else begin
        a = $urandom_range(0, 15);
        b = (a + 1 + $urandom_range(0, 14)) % 16;
        pat = (16'h1 << a) | (16'h1 << b);
      end
      run_frame(pat, 0);
    end
    repeat (3) run_frame('0, 0);
    check("rand_queue_drained", exp_q.size(), 0);
    check("rand_no_overrun", int'(overrun), 0);

    do_reset();
    acc_seen = 0;
    repeat (9) run_frame(16'h1 << 15, 0);
    repeat (3) run_frame('0, 0);
`ifdef REPEAT_EN
    check("holdF_accepts", acc_seen, 4);
`else
    check("holdF_accepts", acc_seen, 1);
`endif
    check("holdF_queue_drained", exp_q.size(), 0);
    auto_ack = 1'b0;

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule
